// File: rtl/otter_intr_csr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | otter_intr_csr_if                                                          |
// | Bundle between the OTTER control unit/datapath and the interrupt CSR unit. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface otter_intr_csr_if;
  logic        intr_ext;
  logic        pc_we;
  logic        csr_WE;
  logic        mret_exec;
  logic        intr_taken;
  logic [11:0] csr_addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic        intr;
  logic [31:0] rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;

  modport master (
    output intr_ext, pc_we, csr_WE, mret_exec, intr_taken, csr_addr, wd, pc,
    input  intr, rd, mtvec, mepc, mie
  );

  modport slave (
    input  intr_ext, pc_we, csr_WE, mret_exec, intr_taken, csr_addr, wd, pc,
    output intr, rd, mtvec, mepc, mie
  );
endinterface
`default_nettype wire

// File: rtl/otter_intr_csr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | otter_intr_csr                                                             |
// | External interrupt sync/edge/pending logic plus mstatus/mtvec/mepc/mcause. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module otter_intr_csr #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
  input  wire                    clk,
  input  wire                    RST,
  otter_intr_csr_if.slave        bus
);

  localparam logic [11:0] C_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] C_ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] C_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] C_ADDR_MCAUSE  = 12'h342;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pending;
  logic                   r_mie;
  logic                   r_mpie;
  logic [31:0]            r_mtvec;
  logic [31:0]            r_mepc;
  logic [31:0]            r_mcause;

  logic                   w_edge;
  logic                   w_mret;
  logic                   w_csr_wr;
  logic [31:0]            w_rd;

  assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_mret   = bus.pc_we & bus.mret_exec;
  assign w_csr_wr = bus.pc_we & bus.csr_WE;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
      r_mie     <= 1'b0;
      r_mpie    <= 1'b0;
      r_mtvec   <= MTVEC_RST;
      r_mepc    <= 32'h0;
      r_mcause  <= 32'h0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.intr_ext};
      r_prev <= r_sync[SYNC_STAGES-1];

      // A fresh edge beats the acknowledge so it is not lost
      if (w_edge) begin
        r_pending <= 1'b1;
      end else if (bus.intr_taken) begin
        r_pending <= 1'b0;
      end

      if (bus.intr_taken) begin
        r_mepc   <= bus.pc;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
        r_mcause <= MCAUSE_EXT;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_csr_wr) begin
        case (bus.csr_addr)
          C_ADDR_MSTATUS: begin
            r_mie  <= bus.wd[3];
            r_mpie <= bus.wd[7];
          end
          C_ADDR_MTVEC:  r_mtvec  <= bus.wd;
          C_ADDR_MEPC:   r_mepc   <= bus.wd;
          C_ADDR_MCAUSE: r_mcause <= bus.wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = 32'h0;
    case (bus.csr_addr)
      C_ADDR_MSTATUS: w_rd = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
      C_ADDR_MTVEC:   w_rd = r_mtvec;
      C_ADDR_MEPC:    w_rd = r_mepc;
      C_ADDR_MCAUSE:  w_rd = r_mcause;
      default:        w_rd = 32'h0;
    endcase
  end

  assign bus.intr  = r_pending & r_mie;
  assign bus.rd    = w_rd;
  assign bus.mtvec = r_mtvec;
  assign bus.mepc  = r_mepc;
  assign bus.mie   = r_mie;

endmodule
`default_nettype wire

// File: tb/tb_otter_intr_csr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_otter_intr_csr                                                          |
// | Directed stimulus with a history-based reference model for otter_intr_csr. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_otter_intr_csr;
  localparam int          SYNC = 2;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0040;
  localparam logic [31:0] MCAUSE_EXT = 32'h8000_000B;

  logic clk = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;

  otter_intr_csr_if bus();

  otter_intr_csr #(
    .SYNC_STAGES (SYNC),
    .MTVEC_RST   (MTVEC_RST),
    .MCAUSE_EXT  (MCAUSE_EXT)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pin history queue, architectural CSR values
  bit          m_valid = 1'b0;
  bit          m_mie, m_mpie, m_pend, m_rise;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  bit          pinlog[$];

  initial forever begin
    @(posedge clk);
    if (RST) begin
      m_mie = 0; m_mpie = 0; m_pend = 0;
      m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0;
      pinlog.delete();
      repeat (SYNC + 1) pinlog.push_front(1'b0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      // pin rose exactly SYNC edges ago
      m_rise = pinlog[SYNC-1] && !pinlog[SYNC];
      if (bus.intr_taken) begin
        m_mepc = bus.pc; m_mpie = m_mie; m_mie = 0; m_mcause = MCAUSE_EXT;
      end else if (bus.pc_we && bus.mret_exec) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (bus.pc_we && bus.csr_WE) begin
        if (bus.csr_addr == 12'h300) begin m_mie = bus.wd[3]; m_mpie = bus.wd[7]; end
        else if (bus.csr_addr == 12'h305) m_mtvec = bus.wd;
        else if (bus.csr_addr == 12'h341) m_mepc = bus.wd;
        else if (bus.csr_addr == 12'h342) m_mcause = bus.wd;
      end
      if (m_rise) m_pend = 1;
      else if (bus.intr_taken) m_pend = 0;
      pinlog.push_front(bus.intr_ext);
      void'(pinlog.pop_back());
    end
  end

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    case (a)
      12'h300: return (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_intr",  {31'h0, bus.intr},  {31'h0, m_pend & m_mie});
      chk("model_mie",   {31'h0, bus.mie},   {31'h0, m_mie});
      chk("model_mtvec", bus.mtvec, m_mtvec);
      chk("model_mepc",  bus.mepc,  m_mepc);
      chk("model_rd",    bus.rd,    exp_rd(bus.csr_addr));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle;
    bus.pc_we = 0; bus.csr_WE = 0; bus.mret_exec = 0; bus.intr_taken = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_addr = a; bus.wd = d; bus.csr_WE = 1; bus.pc_we = 1;
    step(); idle();
  endtask

  initial begin
    RST = 1; idle();
    bus.intr_ext = 0; bus.csr_addr = 12'h342; bus.wd = 0; bus.pc = 0;
    step(2);
    RST = 0;
    settle();
    chk("rst_intr",  {31'h0, bus.intr}, 32'h0);
    chk("rst_mie",   {31'h0, bus.mie},  32'h0);
    chk("rst_mtvec", bus.mtvec, 32'h40);
    chk("rst_mcause", bus.rd, 32'h0);

    // mstatus keeps only MIE/MPIE
    csr_write(12'h300, 32'hFFFF_FFFF);
    settle();
    chk("mstatus_mask", bus.rd, 32'h88);
    chk("mstatus_mie", {31'h0, bus.mie}, 32'h1);

    // latency and single firing
    bus.intr_ext = 1;
    step(); settle(); chk("lat_e1", {31'h0, bus.intr}, 32'h0);
    step(); settle(); chk("lat_e2", {31'h0, bus.intr}, 32'h0);
    step(); settle(); chk("lat_e3", {31'h0, bus.intr}, 32'h1);
    step(2);
    bus.intr_ext = 0;
    bus.intr_taken = 1; bus.pc = 32'h124;
    step(); idle();
    bus.csr_addr = 12'h342; settle();
    chk("entry_mepc",   bus.mepc, 32'h124);
    chk("entry_mcause", bus.rd,   32'h8000_000B);
    chk("entry_intr",   {31'h0, bus.intr}, 32'h0);
    bus.csr_addr = 12'h300; settle();
    chk("entry_mstatus", bus.rd, 32'h80);
    bus.pc_we = 1; bus.mret_exec = 1;
    step(); idle(); step(4); settle();
    chk("fire_once", {31'h0, bus.intr}, 32'h0);
    chk("mret_mie",  {31'h0, bus.mie},  32'h1);

    // pending held while MIE=0, released by mret
    csr_write(12'h300, 32'h80);
    bus.intr_ext = 1; step(3);
    bus.intr_ext = 0; step(3); settle();
    chk("masked_intr", {31'h0, bus.intr}, 32'h0);
    bus.pc_we = 1; bus.mret_exec = 1;
    step(); idle(); settle();
    chk("unmask_mstatus", bus.rd, 32'h88);
    chk("unmask_intr", {31'h0, bus.intr}, 32'h1);

    // edge coincides with intr_taken: set wins
    bus.intr_ext = 1; step(2);
    bus.intr_taken = 1; bus.pc = 32'h200;
    step(); idle(); bus.intr_ext = 0; settle();
    chk("coinc_mepc", bus.mepc, 32'h200);
    chk("coinc_intr_masked", {31'h0, bus.intr}, 32'h0);
    bus.pc_we = 1; bus.mret_exec = 1;
    step(); idle(); settle();
    chk("coinc_kept", {31'h0, bus.intr}, 32'h1);
    bus.intr_taken = 1; bus.pc = 32'h124;
    step(); idle(); step(3);

    // writes and mret need pc_we
    bus.csr_addr = 12'h305; bus.wd = 32'h100;
    bus.csr_WE = 1; bus.mret_exec = 1; bus.pc_we = 0;
    settle(); chk("gate_rd_old", bus.rd, 32'h40);
    step(); idle(); settle();
    chk("gate_mtvec", bus.mtvec, 32'h40);
    chk("gate_mie", {31'h0, bus.mie}, 32'h0);
    bus.csr_WE = 1; bus.pc_we = 1;
    settle(); chk("csrrw_old", bus.rd, 32'h40);
    step(); idle(); settle();
    chk("csrrw_mtvec", bus.mtvec, 32'h100);

    // mid-run reset drops pending
    bus.intr_ext = 1; step(3);
    bus.intr_ext = 0; step(2);
    RST = 1; step(); RST = 0; settle();
    chk("rst2_intr",  {31'h0, bus.intr}, 32'h0);
    chk("rst2_mepc",  bus.mepc,  32'h0);
    chk("rst2_mtvec", bus.mtvec, 32'h40);
    csr_write(12'h300, 32'h8);
    settle();
    chk("rst2_no_pending", {31'h0, bus.intr}, 32'h0);
    csr_write(12'h7C0, 32'hDEAD_BEEF);
    bus.csr_addr = 12'h7C0; settle();
    chk("unmapped_rd", bus.rd, 32'h0);
    chk("unmapped_mtvec", bus.mtvec, 32'h40);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
